// File: rtl/gate_bist_pkg.sv
// Shared types and sizing helpers for the gate BIST checker.
package gate_bist_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   localparam int MAX_N_IN = 4;

   // Number of input vectors walked for an n_in-input gate.
   function automatic int num_vec(input int n_in);
      return 1 << n_in;
   endfunction

   // Bits needed to hold 0..n-1, never less than one.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gate_bist_checker_settle_timer.sv
// Down-counter that measures how long each vector is held; zero marks the compare cycle.
module settle_timer
   import gate_bist_pkg::*;
#(
   parameter int SETTLE = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic en,
   output logic zero
);

   localparam int            CW       = cnt_width(SETTLE);
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = LOAD_VAL;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   // NOTE: flops update with <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/gate_bist_checker.sv
// Walks every input vector of a combinational gate, holds each for SETTLE cycles and
// checks the sampled output against the truth table TT.
module gate_bist_checker
   import gate_bist_pkg::*;
#(
   parameter int                   N_IN   = 2,
   parameter logic [2**N_IN-1:0]   TT     = 4'b1000,
   parameter int                   SETTLE = 10
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   output logic [N_IN-1:0] dut_in,
   input  logic            dut_out,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            first_fail_valid,
   output logic [N_IN-1:0] first_fail_vec
);

   localparam int              NVEC     = num_vec(N_IN);
   localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NVEC - 1);

   if (SETTLE < 1) begin : g_bad_settle
      $error("gate_bist_checker: SETTLE must be at least 1");
   end
   if ((N_IN < 1) || (N_IN > MAX_N_IN)) begin : g_bad_n_in
      $error("gate_bist_checker: N_IN must be in 1..4");
   end

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   err_count_q, err_count_d;
   logic            ffv_q, ffv_d;
   logic [N_IN-1:0] ffvec_q, ffvec_d;
   logic            pass_q, pass_d;

   logic timer_zero;
   logic timer_load;
   logic timer_en;
   logic start_run;
   logic cmp_cycle;
   logic last_vec;
   logic mismatch;

   assign start_run = (state_q == S_IDLE) && start;
   assign cmp_cycle = (state_q == S_SETTLE) && timer_zero;
   assign last_vec  = (vec_q == LAST_VEC);
   assign mismatch  = dut_out ^ TT[vec_q];

   assign timer_load = start_run || (cmp_cycle && !last_vec);
   assign timer_en   = (state_q == S_SETTLE);

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .en   (timer_en),
      .zero (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_SETTLE;
         S_SETTLE: if (cmp_cycle && last_vec) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // Results clear at the start edge; pass is settled on the terminal compare so it is valid during DONE.
   always_comb begin
      vec_d       = vec_q;
      err_count_d = err_count_q;
      ffv_d       = ffv_q;
      ffvec_d     = ffvec_q;
      pass_d      = pass_q;
      if (start_run) begin
         vec_d       = '0;
         err_count_d = '0;
         ffv_d       = 1'b0;
         ffvec_d     = '0;
         pass_d      = 1'b0;
      end else if (cmp_cycle) begin
         if (mismatch) begin
            err_count_d = err_count_q + (N_IN+1)'(1);
            if (!ffv_q) begin
               ffv_d   = 1'b1;
               ffvec_d = vec_q;
            end
         end
         if (last_vec) begin
            pass_d = (err_count_d == '0);
         end else begin
            vec_d = vec_q + N_IN'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q       <= '0;
         err_count_q <= '0;
         ffv_q       <= 1'b0;
         ffvec_q     <= '0;
         pass_q      <= 1'b0;
      end else begin
         vec_q       <= vec_d;
         err_count_q <= err_count_d;
         ffv_q       <= ffv_d;
         ffvec_q     <= ffvec_d;
         pass_q      <= pass_d;
      end
   end

   assign dut_in           = vec_q;
   assign err_count        = err_count_q;
   assign first_fail_valid = ffv_q;
   assign first_fail_vec   = ffvec_q;
   assign pass             = pass_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench for gate_bist_checker: a 2-input instance driven by a selectable gate
// model and a 1-input, SETTLE=1 instance wired to an inverter.
module tb_gate_bist_checker;

   localparam logic [3:0] TT_EXP = 4'b1000;

   typedef struct {
      logic       pass;
      logic [2:0] err;
      logic       ffv;
      logic [1:0] ffvec;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       start1;
   logic [1:0] dut_in;
   logic       dut_out;
   logic       busy, done, pass, ffv;
   logic [2:0] err_count;
   logic [1:0] ffvec;
   logic [0:0] d1_in;
   logic       d1_out;
   logic       busy1, done1, pass1, ffv1;
   logic [1:0] err1;
   logic [0:0] ffvec1;

   int   gut_mode = 0;
   logic glitch   = 1'b0;
   int   n_cmp    = 0;
   int   n_bad    = 0;
   exp_t sb_q[$];
   exp_t sb1_q[$];

   always #5 clk = ~clk;

   // 0 = AND, 1 = OR, anything else = output stuck at 1
   function automatic logic gut_fn(input int mode, input logic [1:0] v);
      case (mode)
         0:       return &v;
         1:       return |v;
         default: return 1'b1;
      endcase
   endfunction

   assign dut_out = gut_fn(gut_mode, dut_in) ^ glitch;
   assign d1_out  = ~d1_in[0];

   gate_bist_checker dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .dut_in           (dut_in),
      .dut_out          (dut_out),
      .busy             (busy),
      .done             (done),
      .pass             (pass),
      .err_count        (err_count),
      .first_fail_valid (ffv),
      .first_fail_vec   (ffvec)
   );

   gate_bist_checker #(
      .N_IN   (1),
      .TT     (2'b01),
      .SETTLE (1)
   ) dut1 (
      .clk              (clk),
      .rst              (rst),
      .start            (start1),
      .dut_in           (d1_in),
      .dut_out          (d1_out),
      .busy             (busy1),
      .done             (done1),
      .pass             (pass1),
      .err_count        (err1),
      .first_fail_valid (ffv1),
      .first_fail_vec   (ffvec1)
   );

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start1 = 1'b0; gut_mode = 0; glitch = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({busy, done, pass, err_count, ffv, ffvec, dut_in} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_dut: got busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d dut_in=%0d, want all 0",
                  busy, done, pass, err_count, ffv, ffvec, dut_in);
      end
      n_cmp++;
      if ({busy1, done1, pass1, err1, ffv1, ffvec1, d1_in} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_dut1: got busy=%b done=%b pass=%b err=%0d ffv=%b dut_in=%0d, want all 0",
                  busy1, done1, pass1, err1, ffv1, d1_in);
      end
      rst = 1'b0;
   endtask

   // One run of the 2-input instance over a 45-cycle window after the start edge.
   // restart_at > 0 pulses start again in that cycle; rst_at > 0 asserts reset in that cycle.
   task automatic do_run(input string name, input int mode, input bit glitch_on,
                         input int restart_at, input int rst_at);
      exp_t       e, got;
      int         done_seen = 0;
      int         done_t    = -1;
      logic [1:0] ev;
      logic [3:0] tt = TT_EXP;
      gut_mode = mode;
      e.pass = 1'b0; e.err = '0; e.ffv = 1'b0; e.ffvec = '0;
      for (int v = 0; v < 4; v++) begin
         ev = v[1:0];
         if (gut_fn(mode, ev) !== tt[v]) begin
            e.err++;
            if (!e.ffv) begin
               e.ffv   = 1'b1;
               e.ffvec = ev;
            end
         end
      end
      e.pass = (e.err == 0);
      if (rst_at == 0) sb_q.push_back(e);

      @(negedge clk);
      start = 1'b1;
      for (int t = 1; t <= 45; t++) begin
         @(negedge clk);
         if (t == 1) begin
            n_cmp++;
            if ({busy, pass, err_count, ffv} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin
               n_bad++;
               $display("FAIL %s start_clear: got busy=%b pass=%b err=%0d ffv=%b, want 1 0 0 0",
                        name, busy, pass, err_count, ffv);
            end
         end
         if ((rst_at == 0 || t < rst_at) && t <= 40 && ((t - 1) % 10 == 0 || t % 10 == 0)) begin
            n_cmp++;
            if (dut_in !== 2'((t - 1) / 10)) begin
               n_bad++;
               $display("FAIL %s dut_in@%0d: got %0d want %0d", name, t, dut_in, (t - 1) / 10);
            end
         end
         if (done) begin
            done_seen++;
            done_t = t;
            n_cmp++;
            if (sb_q.size() == 0) begin
               n_bad++;
               $display("FAIL %s unexpected_done@%0d: got done=1 want no pulse", name, t);
            end else begin
               got = sb_q.pop_front();
               if ({pass, err_count, ffv, ffvec} !== {got.pass, got.err, got.ffv, got.ffvec}) begin
                  n_bad++;
                  $display("FAIL %s result: got pass=%b err=%0d ffv=%b ffvec=%0d want pass=%b err=%0d ffv=%b ffvec=%0d",
                           name, pass, err_count, ffv, ffvec, got.pass, got.err, got.ffv, got.ffvec);
               end
            end
         end
         if (rst_at == 0 && t == 42) begin
            n_cmp++;
            if ({busy, dut_in} !== {1'b0, 2'd3}) begin
               n_bad++;
               $display("FAIL %s after_done: got busy=%b dut_in=%0d want busy=0 dut_in=3", name, busy, dut_in);
            end
         end
         if (rst_at == 0 && t == 45) begin
            n_cmp++;
            if ({pass, err_count, ffv, ffvec} !== {e.pass, e.err, e.ffv, e.ffvec}) begin
               n_bad++;
               $display("FAIL %s held: got pass=%b err=%0d ffv=%b ffvec=%0d want pass=%b err=%0d",
                        name, pass, err_count, ffv, ffvec, e.pass, e.err);
            end
         end
         if (rst_at > 0 && t == rst_at + 1) begin
            n_cmp++;
            if ({busy, done, pass, err_count, ffv, ffvec, dut_in} !== 10'b0) begin
               n_bad++;
               $display("FAIL %s abort: got busy=%b done=%b pass=%b err=%0d ffv=%b ffvec=%0d dut_in=%0d want all 0",
                        name, busy, done, pass, err_count, ffv, ffvec, dut_in);
            end
            rst = 1'b0;
         end
         // drive next-cycle inputs only after this cycle's checks
         start  = (t == restart_at);
         glitch = glitch_on && (t <= 40) && (t % 10 != 0);
         if (rst_at > 0 && t == rst_at) rst = 1'b1;
      end
      start  = 1'b0;
      glitch = 1'b0;
      n_cmp++;
      if (done_seen != ((rst_at == 0) ? 1 : 0)) begin
         n_bad++;
         $display("FAIL %s done_count: got %0d want %0d", name, done_seen, (rst_at == 0) ? 1 : 0);
      end
      if (rst_at == 0) begin
         n_cmp++;
         if (done_t != 41) begin
            n_bad++;
            $display("FAIL %s done_time: got cycle %0d want 41", name, done_t);
         end
      end
   endtask

   task automatic test_and_pass();      do_run("and_pass", 0, 1'b0, 0, 0);  endtask
   task automatic test_glitch();        do_run("glitch", 0, 1'b1, 0, 0);    endtask
   task automatic test_or_fail();       do_run("or_fail", 1, 1'b0, 0, 0);   endtask
   task automatic test_start_ignored(); do_run("restart", 0, 1'b0, 5, 0);   endtask

   task automatic test_stuck_rerun();
      do_run("stuck1_a", 2, 1'b0, 0, 0);
      do_run("stuck1_b", 2, 1'b0, 0, 0);
   endtask

   task automatic test_reset_midrun();
      do_run("rst_mid", 2, 1'b0, 0, 15);
      do_run("post_rst", 0, 1'b0, 0, 0);
   endtask

   task automatic test_back_to_back();
      exp_t e, got;
      int   dts[$];
      int   want_t[3] = '{3, 7, 11};
      e.pass = 1'b1; e.err = '0; e.ffv = 1'b0; e.ffvec = '0;
      repeat (3) sb1_q.push_back(e);
      @(negedge clk);
      start1 = 1'b1;
      for (int t = 1; t <= 14; t++) begin
         @(negedge clk);
         if (t == 1 || t == 2) begin
            n_cmp++;
            if (d1_in !== 1'(t - 1)) begin
               n_bad++;
               $display("FAIL b2b dut_in@%0d: got %0d want %0d", t, d1_in, t - 1);
            end
         end
         if (t == 4 || t == 8 || t == 12) begin
            n_cmp++;
            if (busy1 !== 1'b0) begin
               n_bad++;
               $display("FAIL b2b idle_gap@%0d: got busy=%b want 0", t, busy1);
            end
         end
         if (done1) begin
            dts.push_back(t);
            n_cmp++;
            if (sb1_q.size() == 0) begin
               n_bad++;
               $display("FAIL b2b extra_done@%0d: got done=1 want no pulse", t);
            end else begin
               got = sb1_q.pop_front();
               if ({pass1, err1, ffv1} !== {got.pass, got.err[1:0], got.ffv}) begin
                  n_bad++;
                  $display("FAIL b2b result@%0d: got pass=%b err=%0d ffv=%b want pass=%b err=%0d ffv=%b",
                           t, pass1, err1, ffv1, got.pass, got.err, got.ffv);
               end
            end
         end
         if (t == 11) start1 = 1'b0;
      end
      n_cmp++;
      if (dts.size() != 3) begin
         n_bad++;
         $display("FAIL b2b done_count: got %0d want 3", dts.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dts[i] != want_t[i]) begin
               n_bad++;
               $display("FAIL b2b done_time[%0d]: got cycle %0d want %0d", i, dts[i], want_t[i]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_and_pass();
      test_glitch();
      test_or_fail();
      test_stuck_rerun();
      test_reset_midrun();
      test_start_ignored();
      test_back_to_back();
      n_cmp++;
      if (sb_q.size() != 0 || sb1_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d/%0d entries left want 0/0", sb_q.size(), sb1_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1);
   end

endmodule
